// File: rtl/mux_arb_n_if.sv
// rtl/mux_arb_n_if.sv - channel and output handshake bundle for mux_arb_n
interface mux_arb_n_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] d;
  logic [N-1:0]   d_valid;
  logic [N-1:0]   d_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   z;
  logic           z_valid;
  logic           z_ready;
  logic [SW-1:0]  grant;

  modport master (
    output d, d_valid, mode, sel, z_ready,
    input  d_ready, z, z_valid, grant
  );

  modport slave (
    input  d, d_valid, mode, sel, z_ready,
    output d_ready, z, z_valid, grant
  );
endinterface

// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - registered N-to-1 mux with fixed-select and round-robin modes
module mux_arb_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_arb_n_if.slave  bus
);

  logic [W-1:0]  z_q, z_d;
  logic          z_valid_q, z_valid_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          slot_free;
  logic          eligible;
  logic          take;
  logic [SW-1:0] chosen;
  logic [N-1:0]  d_ready;
  int            idx;

  always_comb begin
    slot_free = !z_valid_q || bus.z_ready;
    eligible  = 1'b0;
    chosen    = '0;
    idx       = 0;
    if (!bus.mode) begin
      // sel beyond the channel count (non-power-of-2 N) simply selects nothing
      if (int'(bus.sel) < N) begin
        eligible = bus.d_valid[bus.sel];
        chosen   = bus.sel;
      end
    end else begin
      // scan from farthest to nearest so the channel closest to ptr wins
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % N;
        if (bus.d_valid[idx]) begin
          eligible = 1'b1;
          chosen   = SW'(idx);
        end
      end
    end
    take    = rst_n && slot_free && eligible;
    d_ready = take ? (N'(1) << chosen) : '0;
  end

  always_comb begin
    z_d       = z_q;
    z_valid_d = z_valid_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    if (take) begin
      z_d       = bus.d[int'(chosen)*W +: W];
      grant_d   = chosen;
      z_valid_d = 1'b1;
      if (bus.mode) begin
        ptr_d = SW'((int'(chosen) + 1) % N);
      end
    end else if (bus.z_ready) begin
      z_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q       <= '0;
      z_valid_q <= 1'b0;
      grant_q   <= '0;
      ptr_q     <= '0;
    end else begin
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.d_ready = d_ready;
  assign bus.z       = z_q;
  assign bus.z_valid = z_valid_q;
  assign bus.grant   = grant_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// tb/tb_mux_arb_n.sv - scoreboard bench for mux_arb_n with a queue-based reference model
module tb_mux_arb_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam logic [N*W-1:0] DATA = 32'h44332211;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_arb_n_if #(.N(N), .W(W)) bus ();
  mux_arb_n #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  mux_arb_n_if #(.N(3), .W(W)) bus3 ();
  mux_arb_n #(.N(3), .W(W)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic [W-1:0] z;
    int           g;
  } item_t;

  item_t        q[$];
  int           m_ptr = 0;
  bit           m_zv = 1'b0;
  logic [N-1:0] exp_ready = '0;
  bit           exp_zv = 1'b0;
  int           n_pass = 0;
  int           n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock of stimulus; the model decides from the rules which channel is taken.
  task automatic cycle(input logic [N-1:0] dv, input logic [N*W-1:0] dd,
                       input bit md, input logic [SW-1:0] sl, input bit zr);
    int ch;
    bit el;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.d_valid = dv;
    bus.d       = dd;
    bus.mode    = md;
    bus.sel     = sl;
    bus.z_ready = zr;
    exp_zv = m_zv;
    el = 1'b0;
    ch = 0;
    if (!md) begin
      if (int'(sl) < N && dv[sl]) begin
        el = 1'b1;
        ch = int'(sl);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!el && dv[(m_ptr + k) % N]) begin
          el = 1'b1;
          ch = (m_ptr + k) % N;
        end
      end
    end
    if (el && (!m_zv || zr)) begin
      exp_ready = N'(1) << ch;
      q.push_back('{dd[ch*W +: W], ch});
      m_zv = 1'b1;
      if (md) m_ptr = (ch + 1) % N;
    end else begin
      exp_ready = '0;
      if (zr) m_zv = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("d_ready", 64'(bus.d_ready), 64'(exp_ready));
      chk("z_valid", 64'(bus.z_valid), 64'(exp_zv));
      if (bus.z_valid) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard: z_valid=1 with z=%0h but no item expected", bus.z);
        end else begin
          chk("z", 64'(bus.z), 64'(q[0].z));
          chk("grant", 64'(bus.grant), 64'(q[0].g));
          if (bus.z_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.d = DATA; bus.d_valid = '1; bus.mode = 1'b0; bus.sel = 2'd2; bus.z_ready = 1'b1;
    bus3.d = 24'h332211; bus3.d_valid = '0; bus3.mode = 1'b0; bus3.sel = '0; bus3.z_ready = 1'b1;
    #12;
    chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
    chk("rst_z", 64'(bus.z), 64'd0);
    chk("rst_z_valid", 64'(bus.z_valid), 64'd0);
    chk("rst_grant", 64'(bus.grant), 64'd0);

    repeat (4) cycle(4'b1111, DATA, 1'b0, 2'd2, 1'b1);
    repeat (5) cycle(4'b1111, DATA, 1'b1, 2'd0, 1'b1);
    cycle(4'b0010, DATA, 1'b1, 2'd0, 1'b1);
    repeat (3) cycle(4'b1010, DATA, 1'b1, 2'd0, 1'b1);
    repeat (3) cycle(4'b1111, DATA, 1'b1, 2'd0, 1'b0);
    repeat (2) cycle(4'b1111, DATA, 1'b1, 2'd0, 1'b1);

    // asynchronous reset while an item sits in z
    cycle(4'b1111, DATA, 1'b1, 2'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_z", 64'(bus.z), 64'd0);
    chk("arst_z_valid", 64'(bus.z_valid), 64'd0);
    chk("arst_grant", 64'(bus.grant), 64'd0);
    chk("arst_d_ready", 64'(bus.d_ready), 64'd0);
    q.delete();
    m_ptr = 0;
    m_zv = 1'b0;
    exp_zv = 1'b0;
    @(posedge clk);
    repeat (3) cycle(4'b1111, DATA, 1'b1, 2'd0, 1'b1);

    // N=3 instance: out-of-range sel
    cycle('0, DATA, 1'b0, 2'd0, 1'b1);
    bus3.d_valid = 3'b111; bus3.sel = 2'd1;
    @(negedge clk);
    chk("n3_ready_sel1", 64'(bus3.d_ready), 64'b010);
    cycle('0, DATA, 1'b0, 2'd0, 1'b1);
    bus3.sel = 2'd3;
    @(negedge clk);
    chk("n3_ready_sel3", 64'(bus3.d_ready), 64'd0);
    chk("n3_z", 64'(bus3.z), 64'h22);
    chk("n3_grant", 64'(bus3.grant), 64'd1);
    chk("n3_z_valid_held", 64'(bus3.z_valid), 64'd1);
    cycle('0, DATA, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    chk("n3_z_valid_drained", 64'(bus3.z_valid), 64'd0);
    chk("n3_ready_still0", 64'(bus3.d_ready), 64'd0);

    repeat (400) cycle(N'($urandom), {$urandom}, 1'($urandom), SW'($urandom),
                       ($urandom % 4) != 0);
    repeat (3) cycle('0, DATA, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
